// File: rtl/gcd_dispatcher.sv
// rtl/gcd_dispatcher.sv - operand-pair queue and sequencer feeding a GCD core, with zero bypass and timeout
// Operand FIFO: circular buffer holding {a,b} pairs in arrival order.
module gcd_dispatcher_fifo #(
  parameter int DW    = 20,
  parameter int DEPTH = 4
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   push,
  input  logic [DW-1:0]          push_data,
  input  logic                   pop,
  output logic [DW-1:0]          head,
  output logic [$clog2(DEPTH):0] count,
  output logic                   full,
  output logic                   empty
);
  localparam int AW = $clog2(DEPTH);
  localparam logic [AW-1:0] PTR_ONE  = AW'(1);
  localparam logic [AW:0]   CNT_ONE  = (AW+1)'(1);
  localparam logic [AW:0]   CNT_FULL = (AW+1)'(DEPTH);

  logic [DW-1:0] mem [DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;

  assign head  = mem[rd_ptr];
  assign full  = (count == CNT_FULL);
  assign empty = (count == '0);

  // Storage write; contents need no reset because count gates every read.
  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= push_data;
  end

  // Pointer and occupancy tracking; pointers wrap naturally since DEPTH is a power of two.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + PTR_ONE;
      if (pop)  rd_ptr <= rd_ptr + PTR_ONE;
      case ({push, pop})
        2'b10:   count <= count + CNT_ONE;
        2'b01:   count <= count - CNT_ONE;
        default: count <= count;
      endcase
    end
  end
endmodule

// Top: dequeues one pair at a time, runs it through the core (or locally for zero operands),
// and holds the tagged result until the consumer takes it.
module gcd_dispatcher #(
  parameter int W       = 10,
  parameter int DEPTH   = 4,
  parameter int TIMEOUT = 1023
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   in_valid,
  output logic                   in_ready,
  input  logic [W-1:0]           in_a,
  input  logic [W-1:0]           in_b,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic [W-1:0]           out_a,
  output logic [W-1:0]           out_b,
  output logic [W-1:0]           out_result,
  output logic                   out_err,
  output logic                   gcd_start,
  output logic [W-1:0]           gcd_a,
  output logic [W-1:0]           gcd_b,
  input  logic [W-1:0]           gcd_result,
  input  logic                   gcd_done,
  output logic [$clog2(DEPTH):0] fifo_count
);
  localparam int TW = $clog2(TIMEOUT + 1);
  localparam logic [TW-1:0] T_LIMIT = TW'(TIMEOUT);
  localparam logic [TW-1:0] T_ONE   = TW'(1);

  typedef enum logic [1:0] {IDLE, ISSUE, WAIT, HOLD} state_t;

  state_t        state;
  logic [W-1:0]  op_a;
  logic [W-1:0]  op_b;
  logic [TW-1:0] tcnt;

  logic [2*W-1:0] head;
  logic [W-1:0]   head_a;
  logic [W-1:0]   head_b;
  logic           fifo_full;
  logic           fifo_empty;
  logic           push;
  logic           pop;

  assign in_ready = !fifo_full;
  assign push     = in_valid && !fifo_full;
  assign pop      = (state == IDLE) && !fifo_empty;
  assign head_a   = head[2*W-1:W];
  assign head_b   = head[W-1:0];

  gcd_dispatcher_fifo #(
    .DW    (2*W),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk       (clk),
    .rst       (rst),
    .push      (push),
    .push_data ({in_a, in_b}),
    .pop       (pop),
    .head      (head),
    .count     (fifo_count),
    .full      (fifo_full),
    .empty     (fifo_empty)
  );

  // Sequencer: done is only looked at in WAIT, so a late done from an abandoned op is harmless.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state      <= IDLE;
      op_a       <= '0;
      op_b       <= '0;
      tcnt       <= '0;
      gcd_start  <= 1'b0;
      gcd_a      <= '0;
      gcd_b      <= '0;
      out_valid  <= 1'b0;
      out_a      <= '0;
      out_b      <= '0;
      out_result <= '0;
      out_err    <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (!fifo_empty) begin
            op_a <= head_a;
            op_b <= head_b;
            if (head_a == '0 || head_b == '0) begin
              out_a      <= head_a;
              out_b      <= head_b;
              out_result <= head_a | head_b;
              out_err    <= (head_a == '0) && (head_b == '0);
              out_valid  <= 1'b1;
              state      <= HOLD;
            end else begin
              gcd_a     <= head_a;
              gcd_b     <= head_b;
              gcd_start <= 1'b1;
              state     <= ISSUE;
            end
          end
        end
        ISSUE: begin
          gcd_start <= 1'b0;
          tcnt      <= '0;
          state     <= WAIT;
        end
        WAIT: begin
          if (gcd_done) begin
            out_a      <= op_a;
            out_b      <= op_b;
            out_result <= gcd_result;
            out_err    <= 1'b0;
            out_valid  <= 1'b1;
            state      <= HOLD;
          end else if (tcnt == T_LIMIT) begin
            out_a      <= op_a;
            out_b      <= op_b;
            out_result <= '0;
            out_err    <= 1'b1;
            out_valid  <= 1'b1;
            state      <= HOLD;
          end else begin
            tcnt <= tcnt + T_ONE;
          end
        end
        HOLD: begin
          if (out_ready) begin
            out_valid <= 1'b0;
            state     <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_gcd_dispatcher.sv
// tb/tb_gcd_dispatcher.sv - directed bench for gcd_dispatcher with a behavioural GCD core stub
module tb_gcd_dispatcher;
  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       in_valid = 1'b0;
  logic       out_ready = 1'b0;
  logic [9:0] in_a = '0;
  logic [9:0] in_b = '0;
  logic       in_ready;
  logic       out_valid;
  logic [9:0] out_a, out_b, out_result;
  logic       out_err;
  logic       gcd_start;
  logic [9:0] gcd_a, gcd_b;
  logic [9:0] gcd_result;
  logic       gcd_done;
  logic [2:0] fifo_count;

  int checks = 0;
  int fails  = 0;

  typedef struct packed {
    logic [9:0] a;
    logic [9:0] b;
    logic [9:0] r;
    logic       e;
  } res_t;
  res_t rq[$];

  // core stub
  int         stub_mode = 0;
  int         stub_cnt  = 0;
  logic       stub_done = 1'b0;
  logic [9:0] stub_res  = '0;
  logic       man_done  = 1'b0;
  logic [9:0] man_res   = '0;

  assign gcd_done   = stub_done | man_done;
  assign gcd_result = man_done ? man_res : stub_res;

  // monitor state
  int         start_cnt = 0;
  int         stab_viol = 0;
  logic       busy = 1'b0;
  logic [9:0] rec_a = '0, rec_b = '0;

  always #5 clk = ~clk;

  gcd_dispatcher #(.W(10), .DEPTH(4), .TIMEOUT(8)) dut (
    .clk        (clk),
    .rst        (rst),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .in_a       (in_a),
    .in_b       (in_b),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .out_a      (out_a),
    .out_b      (out_b),
    .out_result (out_result),
    .out_err    (out_err),
    .gcd_start  (gcd_start),
    .gcd_a      (gcd_a),
    .gcd_b      (gcd_b),
    .gcd_result (gcd_result),
    .gcd_done   (gcd_done),
    .fifo_count (fifo_count)
  );

  function automatic logic [9:0] gcd_fn(input logic [9:0] a, input logic [9:0] b);
    logic [9:0] x, y, t;
    x = a;
    y = b;
    while (y != 0) begin
      t = x % y;
      x = y;
      y = t;
    end
    return x;
  endfunction

  // GCD core stub: done pulse three cycles after start, unless in hung mode
  always @(posedge clk) begin
    if (stub_cnt != 0) stub_cnt <= stub_cnt - 1;
    stub_done <= (stub_cnt == 1);
    if (gcd_start && stub_mode == 0) begin
      stub_cnt <= 3;
      stub_res <= gcd_fn(gcd_a, gcd_b);
    end
  end

  // Collect accepted results, count start pulses, watch operand stability while the core is busy
  always @(negedge clk) begin
    if (out_valid && out_ready) rq.push_back(res_t'{out_a, out_b, out_result, out_err});
    if (!rst) begin
      busy = 1'b0;
    end else if (gcd_start) begin
      start_cnt++;
      busy  = 1'b1;
      rec_a = gcd_a;
      rec_b = gcd_b;
    end else if (busy) begin
      if (gcd_a !== rec_a || gcd_b !== rec_b) stab_viol++;
      if (gcd_done) busy = 1'b0;
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic push_pair(input logic [9:0] a, input logic [9:0] b);
    int k;
    k = 0;
    while (!in_ready && k < 200) begin
      tick();
      k++;
    end
    checks++;
    if (!in_ready) begin
      fails++;
      $display("FAIL push_ready: in_ready=%0b after %0d cycles, required 1", in_ready, k);
    end
    in_valid = 1'b1;
    in_a = a;
    in_b = b;
    tick();
    in_valid = 1'b0;
  endtask

  task automatic wait_q(input int n, input int budget, input string tag);
    int k;
    k = 0;
    while (rq.size() < n && k < budget) begin
      tick();
      k++;
    end
    checks++;
    if (rq.size() < n) begin
      fails++;
      $display("FAIL %s_wait: got %0d results, required %0d", tag, rq.size(), n);
    end
  endtask

  task automatic check_res(input string tag, input res_t exp);
    res_t got;
    got = '0;
    if (rq.size() > 0) got = rq.pop_front();
    checks++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s: got a=%0d b=%0d r=%0d e=%0b, required a=%0d b=%0d r=%0d e=%0b",
               tag, got.a, got.b, got.r, got.e, exp.a, exp.b, exp.r, exp.e);
    end
  endtask

  task automatic test_reset();
    rst = 1'b0;
    repeat (2) tick();
    checks++;
    if ({out_valid, in_ready, gcd_start, out_err} !== 4'b0100) begin
      fails++;
      $display("FAIL reset_flags: got v/rdy/st/err=%b, required 0100", {out_valid, in_ready, gcd_start, out_err});
    end
    checks++;
    if ({out_a, out_b, out_result, gcd_a, gcd_b} !== 50'd0 || fifo_count !== 3'd0) begin
      fails++;
      $display("FAIL reset_data: got data=%h count=%0d, required 0 0", {out_a, out_b, out_result, gcd_a, gcd_b}, fifo_count);
    end
    rst = 1'b1;
    tick();
  endtask

  task automatic test_single();
    int s0;
    rq.delete();
    s0 = start_cnt;
    out_ready = 1'b1;
    push_pair(10'd15, 10'd5);
    tick();
    checks++;
    if (gcd_start !== 1'b1 || gcd_a !== 10'd15 || gcd_b !== 10'd5) begin
      fails++;
      $display("FAIL single_issue: got start=%0b a=%0d b=%0d, required 1 15 5", gcd_start, gcd_a, gcd_b);
    end
    tick();
    checks++;
    if (gcd_start !== 1'b0) begin
      fails++;
      $display("FAIL single_pulse: got start=%0b one cycle later, required 0", gcd_start);
    end
    wait_q(1, 40, "single");
    check_res("single_res", res_t'{10'd15, 10'd5, 10'd5, 1'b0});
    checks++;
    if (start_cnt - s0 !== 1) begin
      fails++;
      $display("FAIL single_starts: got %0d, required 1", start_cnt - s0);
    end
  endtask

  task automatic test_back_to_back();
    int s0, v0;
    rq.delete();
    s0 = start_cnt;
    v0 = stab_viol;
    out_ready = 1'b1;
    push_pair(10'd15, 10'd5);
    push_pair(10'd30, 10'd10);
    push_pair(10'd18, 10'd24);
    wait_q(3, 100, "burst");
    check_res("burst_res0", res_t'{10'd15, 10'd5, 10'd5, 1'b0});
    check_res("burst_res1", res_t'{10'd30, 10'd10, 10'd10, 1'b0});
    check_res("burst_res2", res_t'{10'd18, 10'd24, 10'd6, 1'b0});
    checks++;
    if (start_cnt - s0 !== 3 || stab_viol - v0 !== 0) begin
      fails++;
      $display("FAIL burst_starts: got starts=%0d unstable=%0d, required 3 0", start_cnt - s0, stab_viol - v0);
    end
    repeat (2) tick();
  endtask

  task automatic test_zero_bypass();
    int s0, bad;
    rq.delete();
    s0 = start_cnt;
    out_ready = 1'b0;
    push_pair(10'd0, 10'd12);
    checks++;
    if (out_valid !== 1'b0) begin
      fails++;
      $display("FAIL zero_early: got out_valid=%0b one cycle after push, required 0", out_valid);
    end
    push_pair(10'd0, 10'd0);
    checks++;
    if ({out_valid, out_a, out_b, out_result, out_err} !== {1'b1, 10'd0, 10'd12, 10'd12, 1'b0}) begin
      fails++;
      $display("FAIL zero_first: got v=%0b a=%0d b=%0d r=%0d e=%0b, required 1 0 12 12 0",
               out_valid, out_a, out_b, out_result, out_err);
    end
    bad = 0;
    for (int i = 0; i < 5; i++) begin
      tick();
      if ({out_valid, out_a, out_b, out_result, out_err} !== {1'b1, 10'd0, 10'd12, 10'd12, 1'b0}) bad++;
    end
    checks++;
    if (bad != 0 || fifo_count !== 3'd1) begin
      fails++;
      $display("FAIL zero_hold: got %0d unstable cycles count=%0d, required 0 1", bad, fifo_count);
    end
    out_ready = 1'b1;
    wait_q(2, 20, "zero");
    check_res("zero_res0", res_t'{10'd0, 10'd12, 10'd12, 1'b0});
    check_res("zero_res1", res_t'{10'd0, 10'd0, 10'd0, 1'b1});
    checks++;
    if (start_cnt - s0 !== 0) begin
      fails++;
      $display("FAIL zero_starts: got %0d, required 0", start_cnt - s0);
    end
    repeat (2) tick();
  endtask

  task automatic test_full();
    logic [9:0] ta[6] = '{10'd12, 10'd9, 10'd21, 10'd35, 10'd16, 10'd27};
    logic [9:0] tb[6] = '{10'd8, 10'd6, 10'd14, 10'd25, 10'd12, 10'd18};
    logic [9:0] tr[6] = '{10'd4, 10'd3, 10'd7, 10'd5, 10'd4, 10'd9};
    int acc;
    rq.delete();
    out_ready = 1'b0;
    acc = 0;
    for (int i = 0; i < 6; i++) begin
      in_valid = 1'b1;
      in_a = ta[i];
      in_b = tb[i];
      if (in_ready) acc++;
      tick();
    end
    in_valid = 1'b0;
    checks++;
    if (acc != 5 || fifo_count !== 3'd4 || in_ready !== 1'b0) begin
      fails++;
      $display("FAIL full_fill: got accepted=%0d count=%0d in_ready=%0b, required 5 4 0", acc, fifo_count, in_ready);
    end
    repeat (12) tick();
    checks++;
    if (fifo_count !== 3'd4 || out_valid !== 1'b1) begin
      fails++;
      $display("FAIL full_stall: got count=%0d out_valid=%0b, required 4 1", fifo_count, out_valid);
    end
    out_ready = 1'b1;
    wait_q(5, 200, "full");
    for (int i = 0; i < 5; i++) check_res($sformatf("full_res%0d", i), res_t'{ta[i], tb[i], tr[i], 1'b0});
    checks++;
    if (rq.size() != 0 || fifo_count !== 3'd0) begin
      fails++;
      $display("FAIL full_extra: got leftover=%0d count=%0d, required 0 0", rq.size(), fifo_count);
    end
    repeat (2) tick();
  endtask

  task automatic test_timeout();
    int s0;
    rq.delete();
    s0 = start_cnt;
    stub_mode = 1;
    out_ready = 1'b1;
    push_pair(10'd15, 10'd5);
    push_pair(10'd18, 10'd24);
    wait_q(1, 40, "tmo");
    stub_mode = 0;
    check_res("tmo_abort", res_t'{10'd15, 10'd5, 10'd0, 1'b1});
    wait_q(1, 40, "tmo_next");
    check_res("tmo_next", res_t'{10'd18, 10'd24, 10'd6, 1'b0});
    checks++;
    if (start_cnt - s0 !== 2) begin
      fails++;
      $display("FAIL tmo_starts: got %0d, required 2", start_cnt - s0);
    end
    repeat (2) tick();
  endtask

  task automatic test_reset_mid_wait();
    int bad;
    rq.delete();
    stub_mode = 1;
    out_ready = 1'b1;
    push_pair(10'd12, 10'd8);
    repeat (4) tick();
    checks++;
    if (gcd_a !== 10'd12 || out_valid !== 1'b0) begin
      fails++;
      $display("FAIL rstw_inflight: got gcd_a=%0d out_valid=%0b, required 12 0", gcd_a, out_valid);
    end
    rst = 1'b0;
    #2;
    checks++;
    if ({out_valid, in_ready, gcd_start, out_err, gcd_a, gcd_b, out_result, fifo_count} !== {4'b0100, 30'd0, 3'd0}) begin
      fails++;
      $display("FAIL rstw_async: got v/rdy/st/err=%b a=%0d b=%0d r=%0d count=%0d, required 0100 0 0 0 0",
               {out_valid, in_ready, gcd_start, out_err}, gcd_a, gcd_b, out_result, fifo_count);
    end
    tick();
    rst = 1'b1;
    man_res = 10'd4;
    man_done = 1'b1;
    tick();
    man_done = 1'b0;
    bad = 0;
    for (int i = 0; i < 6; i++) begin
      tick();
      if (out_valid !== 1'b0 || gcd_start !== 1'b0) bad++;
    end
    checks++;
    if (bad != 0 || rq.size() != 0) begin
      fails++;
      $display("FAIL rstw_stale: got %0d spurious cycles, %0d results, required 0 0", bad, rq.size());
    end
    stub_mode = 0;
    push_pair(10'd18, 10'd24);
    wait_q(1, 40, "rstw");
    check_res("rstw_res", res_t'{10'd18, 10'd24, 10'd6, 1'b0});
  endtask

  initial begin
    test_reset();
    test_single();
    test_back_to_back();
    test_zero_bypass();
    test_full();
    test_timeout();
    test_reset_mid_wait();
    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end
endmodule
